// File: rtl/jk_cmd_sequencer_pkg.sv
// Shared definitions for the JK command sequencer: opcodes, FSM states and
// the JK next-state rule used by both the shadow model and the bench.
package jk_cmd_sequencer_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO; head data is valid whenever o_empty is low.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic         w_do_push;
  logic         w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Drives registered J/K for queued {op,count} commands and checks the
// downstream flop's Q against a shadow model.
module jk_cmd_sequencer
  import jk_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [CW-1:0] cmd_count,
  output logic          j,
  output logic          k,
  input  logic          q_fb,
  output logic          busy,
  output logic          model_valid,
  output logic          mismatch,
  output logic [7:0]    mismatch_cnt
);

  localparam int FW = 2 + CW;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [FW-1:0] w_head;
  logic [1:0]    w_head_op;
  logic [CW-1:0] w_head_cnt;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] w_rem_nxt;
  logic [1:0]    r_jk;
  logic [1:0]    w_jk_nxt;

  logic          r_exp_q;
  logic          r_model_valid;
  logic          r_mismatch;
  logic [7:0]    r_mismatch_cnt;

  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && !w_full;
  assign w_head_op  = w_head[FW-1 -: 2];
  assign w_head_cnt = w_head[CW-1:0];

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({cmd_op, cmd_count}),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_jk_nxt    = r_jk;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head_cnt != '0) begin
            w_jk_nxt    = w_head_op;
            w_rem_nxt   = w_head_cnt;
            w_state_nxt = ST_DRIVE;
          end
        end
      end
      ST_DRIVE: begin
        if (r_rem > CW'(1)) begin
          w_rem_nxt = r_rem - CW'(1);
        end else if (!w_empty && (w_head_cnt != '0)) begin
          // Chain the next command on the last cycle so no 00 bubble appears.
          w_pop     = 1'b1;
          w_jk_nxt  = w_head_op;
          w_rem_nxt = w_head_cnt;
        end else begin
          w_pop       = !w_empty;
          w_jk_nxt    = OP_HOLD;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_jk_nxt    = OP_HOLD;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_jk    <= OP_HOLD;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_jk    <= w_jk_nxt;
    end
  end

  // Shadow Q advances on the same edge the flop samples r_jk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_q        <= 1'b0;
      r_model_valid  <= 1'b0;
      r_mismatch     <= 1'b0;
      r_mismatch_cnt <= '0;
    end else begin
      r_exp_q <= jk_next(r_exp_q, r_jk[1], r_jk[0]);
      if ((r_jk == OP_RST) || (r_jk == OP_SET)) r_model_valid <= 1'b1;
      if (r_model_valid && (q_fb != r_exp_q)) begin
        r_mismatch <= 1'b1;
        if (r_mismatch_cnt != 8'hFF) r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
      end
    end
  end

  assign j            = r_jk[1];
  assign k            = r_jk[0];
  assign busy         = (r_state == ST_DRIVE) || !w_empty;
  assign model_valid  = r_model_valid;
  assign mismatch     = r_mismatch;
  assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: stimulus pushes expected per-cycle {j,k} into a queue; a
// negedge monitor pops and compares while the sequencer is busy.
module tb_jk_cmd_sequencer;
  import jk_cmd_sequencer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          j;
  logic          k;
  logic          q_fb;
  logic          busy;
  logic          model_valid;
  logic          mismatch;
  logic [7:0]    mismatch_cnt;

  // Downstream JK flop, starting in a state the shadow model does not know.
  logic flop_q = 1'b1;
  logic force_en = 1'b0;
  logic force_val = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_jk [$];

  jk_cmd_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_count    (cmd_count),
    .j            (j),
    .k            (k),
    .q_fb         (q_fb),
    .busy         (busy),
    .model_valid  (model_valid),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) flop_q <= jk_next(flop_q, j, k);
  assign q_fb = force_en ? force_val : flop_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected {j,k} per busy cycle; idle cycles must show 00.
  always @(negedge clk) begin
    if (busy) begin
      if (exp_jk.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL jk_unexpected: got %0b expected nothing at %0t", {j, k}, $time);
      end else begin
        check("jk_stream", {30'd0, j, k}, {30'd0, exp_jk.pop_front()});
      end
    end else begin
      check("jk_idle", {30'd0, j, k}, 32'd0);
    end
  end

  task automatic expect_run(input logic [1:0] op, input int n);
    for (int i = 0; i < n; i++) exp_jk.push_back(op);
  endtask

  // Starts and ends at a negedge; returns the number of cycles spent stalled.
  task automatic push(input logic [1:0] op, input logic [CW-1:0] cnt, output int waited);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_count = cnt;
    waited    = 0;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) check("push_timeout", 32'(waited), 32'd0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (i >= 200) check("idle_timeout", 32'(i), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_j", 32'(j), 32'd0);
    check("rst_k", 32'(k), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_model_valid", 32'(model_valid), 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    int w;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_count = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);

    // Toggle alone never validates the model, so an unknown flop Q is ignored.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_TGL, 2);
    push(OP_TGL, 4'd2, w);
    wait_idle();
    check("tgl_model_valid", 32'(model_valid), 32'd0);
    check("tgl_mismatch", 32'(mismatch), 32'd0);

    // SET for 3 cycles.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_SET, 3);
    push(OP_SET, 4'd3, w);
    wait_idle();
    check("set_q", 32'(q_fb), 32'd1);
    check("set_model_valid", 32'(model_valid), 32'd1);
    check("set_mismatch", 32'(mismatch), 32'd0);

    // RST,1 then TGL,4 gapless.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_RST, 1);
    expect_run(OP_TGL, 4);
    push(OP_RST, 4'd1, w);
    push(OP_TGL, 4'd4, w);
    wait_idle();
    check("chain_q", 32'(q_fb), 32'd0);
    check("chain_mismatch", 32'(mismatch), 32'd0);

    // Zero-count entry leaves exactly one 00 cycle between runs.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_SET, 2);
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_RST, 2);
    push(OP_SET, 4'd2, w);
    push(OP_HOLD, 4'd0, w);
    push(OP_RST, 4'd2, w);
    wait_idle();
    check("zero_q", 32'(q_fb), 32'd0);
    check("zero_mismatch", 32'(mismatch), 32'd0);

    // Fill the FIFO behind a max-length run.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_SET, 15);
    expect_run(OP_TGL, 1);
    expect_run(OP_RST, 2);
    expect_run(OP_SET, 1);
    expect_run(OP_TGL, 2);
    expect_run(OP_RST, 1);
    push(OP_SET, 4'd15, w);
    push(OP_TGL, 4'd1, w);
    push(OP_RST, 4'd2, w);
    push(OP_SET, 4'd1, w);
    check("full_ready_before_4th", 32'(cmd_ready), 32'd1);
    push(OP_TGL, 4'd2, w);
    check("full_ready_dropped", 32'(cmd_ready), 32'd0);
    push(OP_RST, 4'd1, w);
    check("full_5th_stall_cycles", 32'(w), 32'd12);
    wait_idle();
    check("full_q", 32'(q_fb), 32'd0);
    check("full_mismatch", 32'(mismatch), 32'd0);

    // Hold Q low against an expected 1 for three edges.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_SET, 2);
    push(OP_SET, 4'd2, w);
    wait_idle();
    check("pre_force_q", 32'(q_fb), 32'd1);
    force_val = 1'b0;
    force_en  = 1'b1;
    repeat (3) @(negedge clk);
    force_en = 1'b0;
    check("force_mismatch", 32'(mismatch), 32'd1);
    check("force_mismatch_cnt", 32'(mismatch_cnt), 32'd3);
    @(negedge clk);
    check("force_sticky_cnt", 32'(mismatch_cnt), 32'd3);

    // Reset abandons a TGL,8 run after three driven cycles.
    exp_jk.push_back(OP_HOLD);
    expect_run(OP_TGL, 3);
    push(OP_TGL, 4'd8, w);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    @(negedge clk);

    check("scoreboard_drained", 32'(exp_jk.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
